// File: rtl/idu_decode_queue.sv
// Registered RV32 decoder feeding a DEPTH-entry FIFO between IFU and EXU.
// Optional feature macro: IDU_ILLEGAL_CNT_EN adds a saturating 16-bit illegal_cnt output.

// Instruction-number values from inst.vh; defined here only when it was not already included.
`ifndef INST_INV
`define INST_INV     0
`define INST_LUI     1
`define INST_AUIPC   2
`define INST_JAL     3
`define INST_JALR    4
`define INST_BEQ     5
`define INST_BNE     6
`define INST_LW      7
`define INST_LBU     8
`define INST_SH      9
`define INST_SW      10
`define INST_ADDI    11
`define INST_SLTIU   12
`define INST_SRLI    13
`define INST_SRAI    14
`define INST_ADD     15
`define INST_SUB     16
`define INST_SLTU    17
`define INST_IXOR    18
`define INST_IOR     19
`define INST_EBREAK  20
`endif

module idu_decode_queue #(
    parameter int ISA_WIDTH      = 32,
    parameter int INST_NUM_WIDTH = 8,
    parameter int DEPTH          = 2,
    parameter int PTR_WIDTH      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ISA_WIDTH-1:0]      in_inst,
    input  logic [ISA_WIDTH-1:0]      in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INST_NUM_WIDTH-1:0] out_inst_num,
    output logic [ISA_WIDTH-1:0]      out_inst,
    output logic [ISA_WIDTH-1:0]      out_pc,
    output logic                      out_illegal
`ifdef IDU_ILLEGAL_CNT_EN
    ,
    output logic [15:0]               illegal_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high and flush is low; ready never depends on the opposite side's valid/ready.

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [ISA_WIDTH-1:0]      EBREAK_WORD = ISA_WIDTH'(32'h0010_0073);
    localparam logic [INST_NUM_WIDTH-1:0] NUM_INV     = INST_NUM_WIDTH'(`INST_INV);
    localparam logic [PTR_WIDTH:0]        COUNT_FULL  = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH-1:0]      PTR_ONE     = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]        COUNT_ONE   = (PTR_WIDTH+1)'(1);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PARTIAL = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      bit30;
    logic [INST_NUM_WIDTH-1:0] dec_num;

    logic [INST_NUM_WIDTH-1:0] q_num  [DEPTH];
    logic [ISA_WIDTH-1:0]      q_inst [DEPTH];
    logic [ISA_WIDTH-1:0]      q_pc   [DEPTH];
    logic [PTR_WIDTH-1:0]      rd_ptr;
    logic [PTR_WIDTH-1:0]      wr_ptr;
    logic [PTR_WIDTH:0]        count;
    logic [1:0]                state;
    logic                      push;
    logic                      pop;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign bit30  = in_inst[30];

    always_comb begin
        dec_num = NUM_INV;
        case (opcode)
            OP_LUI:   dec_num = INST_NUM_WIDTH'(`INST_LUI);
            OP_AUIPC: dec_num = INST_NUM_WIDTH'(`INST_AUIPC);
            OP_JAL:   dec_num = INST_NUM_WIDTH'(`INST_JAL);
            OP_JALR:  if (funct3 == 3'b000) dec_num = INST_NUM_WIDTH'(`INST_JALR);
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  dec_num = INST_NUM_WIDTH'(`INST_BEQ);
                    3'b001:  dec_num = INST_NUM_WIDTH'(`INST_BNE);
                    default: dec_num = NUM_INV;
                endcase
            end
            OP_LOAD: begin
                case (funct3)
                    3'b010:  dec_num = INST_NUM_WIDTH'(`INST_LW);
                    3'b100:  dec_num = INST_NUM_WIDTH'(`INST_LBU);
                    default: dec_num = NUM_INV;
                endcase
            end
            OP_STORE: begin
                case (funct3)
                    3'b001:  dec_num = INST_NUM_WIDTH'(`INST_SH);
                    3'b010:  dec_num = INST_NUM_WIDTH'(`INST_SW);
                    default: dec_num = NUM_INV;
                endcase
            end
            // Only bit 30 separates the shift/arith variants; other funct7 bits are don't-care.
            OP_IMM: begin
                case (funct3)
                    3'b000:  dec_num = INST_NUM_WIDTH'(`INST_ADDI);
                    3'b011:  dec_num = INST_NUM_WIDTH'(`INST_SLTIU);
                    3'b101:  dec_num = bit30 ? INST_NUM_WIDTH'(`INST_SRAI) : INST_NUM_WIDTH'(`INST_SRLI);
                    default: dec_num = NUM_INV;
                endcase
            end
            OP_OP: begin
                case (funct3)
                    3'b000:  dec_num = bit30 ? INST_NUM_WIDTH'(`INST_SUB) : INST_NUM_WIDTH'(`INST_ADD);
                    3'b011:  dec_num = INST_NUM_WIDTH'(`INST_SLTU);
                    3'b100:  dec_num = INST_NUM_WIDTH'(`INST_IXOR);
                    3'b110:  dec_num = INST_NUM_WIDTH'(`INST_IOR);
                    default: dec_num = NUM_INV;
                endcase
            end
            OP_SYSTEM: if (in_inst == EBREAK_WORD) dec_num = INST_NUM_WIDTH'(`INST_EBREAK);
            default:   dec_num = NUM_INV;
        endcase
    end

    always_comb begin
        if (count == '0) begin
            state = S_EMPTY;
        end else if (count == COUNT_FULL) begin
            state = S_FULL;
        end else begin
            state = S_PARTIAL;
        end
    end

    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_num[i]  <= NUM_INV;
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_num[wr_ptr]  <= dec_num;
                q_inst[wr_ptr] <= in_inst;
                q_pc[wr_ptr]   <= in_pc;
                wr_ptr         <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + COUNT_ONE;
            end else if (pop && !push) begin
                count <= count - COUNT_ONE;
            end
        end
    end

    assign out_inst_num = q_num[rd_ptr];
    assign out_inst     = q_inst[rd_ptr];
    assign out_pc       = q_pc[rd_ptr];
    assign out_illegal  = (q_num[rd_ptr] == NUM_INV);

`ifdef IDU_ILLEGAL_CNT_EN
    // Counts accepted illegal words only; survives flush so redirects do not hide them.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (push && (dec_num == NUM_INV) && (illegal_cnt != 16'hFFFF)) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_idu_decode_queue.sv
// Directed bench for idu_decode_queue: decode table, backpressure, simultaneous push/pop, flush, reset.
// Counter checks are compiled in when IDU_ILLEGAL_CNT_EN is defined.

module tb_idu_decode_queue;

    localparam int N_INV = 0,  N_LUI = 1,  N_AUIPC = 2,  N_JAL = 3,  N_JALR = 4;
    localparam int N_BEQ = 5,  N_BNE = 6,  N_LW = 7,     N_LBU = 8,  N_SH = 9;
    localparam int N_SW = 10,  N_ADDI = 11, N_SLTIU = 12, N_SRLI = 13, N_SRAI = 14;
    localparam int N_ADD = 15, N_SUB = 16, N_SLTU = 17,  N_IXOR = 18, N_IOR = 19;
    localparam int N_EBREAK = 20;
    localparam int NVEC = 28;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_inst_num;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_illegal;
`ifdef IDU_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    logic [31:0] dec_inst [NVEC] = '{
        32'h0050_0093, 32'h4030_D093, 32'h4020_81B3, 32'h0010_0073,
        32'h0000_00B7, 32'h0000_0017, 32'h0000_006F, 32'h0000_8067,
        32'h0000_1067, 32'h0000_0063, 32'h0000_1063, 32'h0000_4063,
        32'h0000_2003, 32'h0000_4003, 32'h0000_1003, 32'h0000_1023,
        32'h0000_2023, 32'h0000_0023, 32'h0000_3013, 32'h0050_D093,
        32'h0200_0033, 32'h0000_3033, 32'h0000_4033, 32'h0000_6033,
        32'h0000_7033, 32'h0000_0073, 32'h0000_007F, 32'h4000_4033
    };
    int dec_exp [NVEC] = '{
        N_ADDI,  N_SRAI,  N_SUB,   N_EBREAK,
        N_LUI,   N_AUIPC, N_JAL,   N_JALR,
        N_INV,   N_BEQ,   N_BNE,   N_INV,
        N_LW,    N_LBU,   N_INV,   N_SH,
        N_SW,    N_INV,   N_SLTIU, N_SRLI,
        N_ADD,   N_SLTU,  N_IXOR,  N_IOR,
        N_INV,   N_INV,   N_INV,   N_IXOR
    };

    always #5 clk = ~clk;

    idu_decode_queue #(
        .ISA_WIDTH(32),
        .INST_NUM_WIDTH(8),
        .DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_inst(in_inst),
        .in_pc(in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst_num(out_inst_num),
        .out_inst(out_inst),
        .out_pc(out_pc),
        .out_illegal(out_illegal)
`ifdef IDU_ILLEGAL_CNT_EN
        ,
        .illegal_cnt(illegal_cnt)
`endif
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        tick(); tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_inst_num !== 8'(N_INV)) begin bad++; $display("FAIL reset_inst_num got=%0d want=%0d", out_inst_num, N_INV); end
        total++; if (out_illegal !== 1'b1) begin bad++; $display("FAIL reset_illegal got=%b want=1", out_illegal); end
`ifdef IDU_ILLEGAL_CNT_EN
        total++; if (illegal_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", illegal_cnt); end
`endif
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1;
        in_inst = 32'h0000_7013; in_pc = 32'h0000_0200;
        tick();
        in_valid = 1'b0;
        exp_cnt++;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL illegal_valid got=%b want=1", out_valid); end
        total++; if (out_inst_num !== 8'(N_INV)) begin bad++; $display("FAIL illegal_num got=%0d want=%0d", out_inst_num, N_INV); end
        total++; if (out_illegal !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b want=1", out_illegal); end
`ifdef IDU_ILLEGAL_CNT_EN
        total++; if (illegal_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL illegal_cnt got=%0d want=%0d", illegal_cnt, exp_cnt); end
`endif
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            in_valid = 1'b1;
            in_inst  = dec_inst[i];
            in_pc    = 32'h0000_1000 + 32'(4 * i);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dec_in_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
            if (dec_exp[i] == N_INV) exp_cnt++;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dec_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (out_inst_num !== 8'(dec_exp[i])) begin bad++; $display("FAIL dec_num[%0d] inst=%h got=%0d want=%0d", i, dec_inst[i], out_inst_num, dec_exp[i]); end
            total++; if (out_illegal !== (dec_exp[i] == N_INV)) begin bad++; $display("FAIL dec_illegal[%0d] got=%b want=%b", i, out_illegal, dec_exp[i] == N_INV); end
            total++; if (out_inst !== dec_inst[i]) begin bad++; $display("FAIL dec_inst[%0d] got=%h want=%h", i, out_inst, dec_inst[i]); end
            total++; if (out_pc !== 32'h0000_1000 + 32'(4 * i)) begin bad++; $display("FAIL dec_pc[%0d] got=%h want=%h", i, out_pc, 32'h0000_1000 + 32'(4 * i)); end
`ifdef IDU_ILLEGAL_CNT_EN
            total++; if (illegal_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL dec_cnt[%0d] got=%0d want=%0d", i, illegal_cnt, exp_cnt); end
`endif
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dec_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [$];
        logic [31:0] words [3] = '{32'h0000_00B7, 32'h0000_8067, 32'h0000_0063};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = words[i]; in_pc = 32'h0000_0100 + 32'(4 * i);
            if (i < 2) exp_q.push_back(words[i]);
            tick();
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        total++; if (out_inst !== 32'h0000_00B7) begin bad++; $display("FAIL bp_head got=%h want=%h", out_inst, 32'h0000_00B7); end
        total++; if (out_inst_num !== 8'(N_LUI)) begin bad++; $display("FAIL bp_head_num got=%0d want=%0d", out_inst_num, N_LUI); end
        out_ready = 1'b1;
        // First drain edge frees a slot but cannot also accept, so the third word lands one edge later.
        tick();
        void'(exp_q.pop_front());
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%b want=1", in_ready); end
        total++; if (out_inst !== exp_q[0]) begin bad++; $display("FAIL bp_drain1 got=%h want=%h", out_inst, exp_q[0]); end
        exp_q.push_back(words[2]);
        tick();
        in_valid = 1'b0;
        void'(exp_q.pop_front());
        total++; if (out_inst !== exp_q[0]) begin bad++; $display("FAIL bp_drain2 got=%h want=%h", out_inst, exp_q[0]); end
        total++; if (out_pc !== 32'h0000_0108) begin bad++; $display("FAIL bp_drain2_pc got=%h want=%h", out_pc, 32'h0000_0108); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] words [5] = '{32'h0000_2003, 32'h0000_4003, 32'h0000_1023, 32'h0000_2023, 32'h0000_4033};
        int          nums  [5] = '{N_LW, N_LBU, N_SH, N_SW, N_IXOR};
        out_ready = 1'b0; in_valid = 1'b1; in_inst = words[0]; in_pc = 32'h0000_0300;
        tick();
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            in_inst = words[i]; in_pc = 32'h0000_0300 + 32'(4 * i);
            tick();
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL sim_count[%0d] valid=%b ready=%b want=1/1", i, out_valid, in_ready); end
            total++; if (out_inst_num !== 8'(nums[i])) begin bad++; $display("FAIL sim_num[%0d] got=%0d want=%0d", i, out_inst_num, nums[i]); end
            total++; if (out_pc !== 32'h0000_0300 + 32'(4 * i)) begin bad++; $display("FAIL sim_pc[%0d] got=%h want=%h", i, out_pc, 32'h0000_0300 + 32'(4 * i)); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sim_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h0000_3033; in_pc = 32'h0000_0400; tick();
        in_inst = 32'h0000_6033; in_pc = 32'h0000_0404; tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_full got=%b want=0", in_ready); end
        // Illegal word in the flush cycle must neither enter nor bump the counter.
        flush = 1'b1; out_ready = 1'b1; in_inst = 32'h0000_7013; in_pc = 32'h0000_0408;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%b want=1", in_ready); end
`ifdef IDU_ILLEGAL_CNT_EN
        total++; if (illegal_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL fl_cnt got=%0d want=%0d", illegal_cnt, exp_cnt); end
`endif
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost got=%b want=0", out_valid); end
        in_valid = 1'b1; in_inst = 32'h0000_0017; in_pc = 32'h0000_0500;
        tick();
        in_valid = 1'b0;
        total++; if (out_inst_num !== 8'(N_AUIPC) || out_pc !== 32'h0000_0500) begin bad++; $display("FAIL fl_refill got=%0d/%h want=%0d/%h", out_inst_num, out_pc, N_AUIPC, 32'h0000_0500); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_refill_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h0000_0073; in_pc = 32'h0000_0600; tick();
        in_inst = 32'h0000_2003; in_pc = 32'h0000_0604; tick();
        exp_cnt++;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_full got=%b want=0", in_ready); end
`ifdef IDU_ILLEGAL_CNT_EN
        total++; if (illegal_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL rm_cnt_pre got=%0d want=%0d", illegal_cnt, exp_cnt); end
`endif
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", in_ready); end
        total++; if (out_inst_num !== 8'(N_INV)) begin bad++; $display("FAIL rm_num got=%0d want=%0d", out_inst_num, N_INV); end
        total++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin bad++; $display("FAIL rm_storage got=%h/%h want=0/0", out_inst, out_pc); end
`ifdef IDU_ILLEGAL_CNT_EN
        total++; if (illegal_cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt got=%0d want=0", illegal_cnt); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_illegal();
        test_decode();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idu_decode_queue.md
Name: idu_decode_queue

Overview:
Registered RV32 instruction decoder with a parametrised output queue.
- Sits between IFU and EXU.
- Accepts raw instructions with PC over a valid/ready handshake.
- Fully resolves opcode, funct3 and funct7 (bit 30) into one instruction number, taken from the instruction-number macros in inst.vh.
- Buffers up to DEPTH decoded entries.
- Supports a synchronous flush for redirects.
- Successor to the per-funct3 combinational sub-decoders: single-stage full decode, handshaking, buffering.

Parameters:
ISA_WIDTH, 32, instruction and PC width.
INST_NUM_WIDTH, 8, width of the decoded instruction number.
DEPTH, 2, queue entries; power of two, >= 2.
PTR_WIDTH, $clog2(DEPTH), read/write pointer width; count register is PTR_WIDTH+1 bits.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous queue clear (branch/jump redirect)
in_valid  input  1  IFU has an instruction
in_ready  output  1  queue can accept this cycle
in_inst  input  ISA_WIDTH  raw instruction
in_pc  input  ISA_WIDTH  instruction PC
out_valid  output  1  head entry valid
out_ready  input  1  EXU consumes head
out_inst_num  output  INST_NUM_WIDTH  decoded instruction number of head
out_inst  output  ISA_WIDTH  raw instruction of head
out_pc  output  ISA_WIDTH  PC of head
out_illegal  output  1  head decoded to `inv

Behaviour:
Decode (combinational, on the in_* side, result written into the queue):
- Opcode selects the class.
- Class lui/auipc/jal/jalr: fixed number; jalr additionally requires funct3=000.
- Class branch: funct3 000=`beq, 001=`bne.
- Class load: 010=`lw, 100=`lbu.
- Class store: 001=`sh, 010=`sw.
- Class op-imm: 000=`addi, 011=`sltiu, 101 with bit30=0 `srli / bit30=1 `srai.
- Class op: 000 with bit30=0 `add / bit30=1 `sub; 011=`sltu, 100=`ixor, 110=`ior.
- Class system: inst==0x00100073 gives `ebreak.
- Every other opcode/funct3/funct7 combination gives `inv.
- The srai/srli/add/sub funct7 check is on bit 30 only; other funct7 bits are ignored.
- out_illegal is high exactly when out_inst_num==`inv.

Queue:
- Circular buffer with read pointer, write pointer and count (0..DEPTH).
- in_ready = (count != DEPTH). It is registered-state only and never depends on out_ready.
- out_valid = (count != 0). out_* are driven from the head entry.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, a pop does not enable a same-cycle push, because in_ready was already low.
- Pointers wrap modulo DEPTH.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 if the queue was empty.
- Order is strictly FIFO.
- Outputs are stable while out_valid & ~out_ready.
- No sequential FSM beyond the count. State is EMPTY (count=0), PARTIAL, or FULL (count=DEPTH).

Flush:
- Next cycle, count=0 and both pointers=0.
- Any push or pop in the flush cycle is discarded.
- in_ready reads 1 the cycle after flush.

Reset (rst=1 at edge):
- count=0, pointers=0, out_valid=0, in_ready=1.
- Entry storage is cleared to 0, with out_inst_num=`inv for the head.
- rst has priority over flush.
- Reset mid-stream drops all entries.

Optional Feature:
Macro IDU_ILLEGAL_CNT_EN.
- Defined:
  - Adds output port illegal_cnt, 16 bits.
  - Increments by 1 on each push whose decoded number is `inv.
  - Saturates at 0xFFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Decode coverage: push 0x00500093, then 0x4030D093, then 0x402081B3, then 0x00100073 with out_ready=1 -> out_inst_num sequence `addi, `srai, `sub, `ebreak, each one cycle after accept; out_pc matches the corresponding in_pc.
- Illegal: push 0x00007013 (andi) -> out_inst_num=`inv, out_illegal=1. With IDU_ILLEGAL_CNT_EN, illegal_cnt goes 0 -> 1.
- Backpressure: DEPTH=2, out_ready=0, push 3 instructions -> third is held (in_ready=0 after two accepts); head stays first instruction. Raising out_ready drains all three in order.
- Simultaneous: count=1, in_valid=1 and out_ready=1 for 4 cycles -> count stays 1, outputs change each cycle, no loss or duplication.
- Flush: queue holds 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction never appears.
- Reset: assert rst mid-stream with the queue full -> next cycle out_valid=0, in_ready=1, out_inst_num=`inv, illegal_cnt=0.
